// File: rtl/uarch_pkg.sv
// Shared micro-architecture types for the LSQ/AGU datapath.
// Holds the issue/writeback packets and the AGU helper types.
package uarch_pkg;

    localparam int XLEN  = 32;
    localparam int TAG_W = 6;

    typedef struct packed {
        logic [XLEN-1:0] data;
    } operand_t;

    typedef struct packed {
        logic             is_valid;
        logic [TAG_W-1:0] dest_tag;
        operand_t         src_0_a;
        operand_t         src_0_b;
    } instruction_t;

    typedef struct packed {
        logic             is_valid;
        logic [TAG_W-1:0] dest_tag;
        logic [XLEN-1:0]  result;
        logic             exception;
    } writeback_packet_t;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2,
        MEM_RSVD = 2'd3
    } mem_size_e;

    typedef logic [1:0] agu_split_t;

    localparam agu_split_t SPLIT_NONE  = 2'b00;
    localparam agu_split_t SPLIT_BEAT1 = 2'b01;
    localparam agu_split_t SPLIT_BEAT2 = 2'b10;

    typedef enum logic {
        AGU_IDLE   = 1'b0,
        AGU_SPLIT1 = 1'b1
    } agu_fsm_e;

    // Payload held by the first slice: raw operands, not yet added.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        mem_size_e        size;
    } agu_raw_t;

    // Payload held by later slices: resolved address and access info.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  addr;
        logic [7:0]       m8;
        logic             exc;
        logic             split;
    } agu_addr_t;

    // Byte enables over two adjacent words; the reserved size
    // is given a full-word footprint.
    function automatic logic [7:0] agu_byte_mask(
        input logic [1:0] off,
        input mem_size_e  size
    );
        logic [7:0] base;
        unique case (size)
            MEM_BYTE: base = 8'h01;
            MEM_HALF: base = 8'h03;
            default:  base = 8'h0F;
        endcase
        return base << off;
    endfunction

    function automatic logic agu_misaligned(
        input logic [1:0] off,
        input mem_size_e  size
    );
        logic mis;
        unique case (size)
            MEM_BYTE: mis = 1'b0;
            MEM_HALF: mis = off[0];
            MEM_WORD: mis = (off != 2'b00);
            default:  mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/agu_pipe_stage.sv
// One elastic register slice of the AGU pipeline.
// Loads whenever it is empty or its content is leaving.
module agu_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_ready
);

    logic         r_valid;
    logic [W-1:0] r_data;

    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Slice register: flush kills content, otherwise load on space.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/agu_pipe.sv
// Elastic address generation unit: add, align check, byte mask,
// optional splitting of misaligned accesses into two word beats.
module agu_pipe #(
    parameter int STAGES           = 2,
    parameter bit SPLIT_MISALIGNED = 1'b0,
    parameter int XLEN             = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  uarch_pkg::instruction_t      agu_packet,
    input  logic [1:0]                   agu_size,
    output logic                         agu_ready,
    output uarch_pkg::writeback_packet_t agu_result,
    input  logic                         result_ready,
    output logic [3:0]                   result_mask,
    output logic [1:0]                   result_split
);

    import uarch_pkg::*;

    localparam int RAW_W = $bits(agu_raw_t);
    localparam int ADR_W = $bits(agu_addr_t);

    agu_raw_t        w_raw_in;
    agu_raw_t        w_s0_data;
    logic            w_in_valid;
    logic            w_s0_ready;
    logic            w_s0_valid;
    logic            w_s0_dn_ready;
    logic [XLEN-1:0] w_sum;
    agu_addr_t       w_calc;
    agu_addr_t       w_head;
    logic            w_last_valid;
    logic            w_adv;
    logic [XLEN-1:0] w_base;
    agu_fsm_e        r_state;
    agu_fsm_e        w_state_nxt;

    assign w_in_valid = agu_packet.is_valid && !flush;
    assign agu_ready  = w_s0_ready && !flush;

    // Repack the issued uop into the first slice payload.
    always_comb begin
        w_raw_in      = '0;
        w_raw_in.tag  = agu_packet.dest_tag;
        w_raw_in.a    = agu_packet.src_0_a.data;
        w_raw_in.b    = agu_packet.src_0_b.data;
        w_raw_in.size = mem_size_e'(agu_size);
    end

    agu_stage #(.W(RAW_W)) u_stage0 (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_valid (w_in_valid),
        .i_data  (w_raw_in),
        .o_ready (w_s0_ready),
        .o_valid (w_s0_valid),
        .o_data  (w_s0_data),
        .i_ready (w_s0_dn_ready)
    );

    assign w_sum = w_s0_data.a + w_s0_data.b;

    // Resolve address, mask and alignment from the first slice.
    always_comb begin
        logic w_mis;
        logic w_rsvd;
        w_mis        = agu_misaligned(w_sum[1:0], w_s0_data.size);
        w_rsvd       = (w_s0_data.size == MEM_RSVD);
        w_calc       = '0;
        w_calc.tag   = w_s0_data.tag;
        w_calc.addr  = w_sum;
        w_calc.m8    = agu_byte_mask(w_sum[1:0], w_s0_data.size);
        w_calc.exc   = w_mis && (!SPLIT_MISALIGNED || w_rsvd);
        w_calc.split = w_mis && SPLIT_MISALIGNED && !w_rsvd;
    end

    generate
        if (STAGES == 1) begin : g_one
            assign w_head        = w_calc;
            assign w_last_valid  = w_s0_valid;
            assign w_s0_dn_ready = w_adv;
        end else begin : g_many
            localparam int NB = STAGES - 1;
            logic      w_v [NB];
            logic      w_r [NB];
            agu_addr_t w_d [NB];
            for (genvar j = 0; j < NB; j++) begin : g_st
                logic      w_iv;
                logic      w_dr;
                agu_addr_t w_id;
                if (j == 0) begin : g_first
                    assign w_iv          = w_s0_valid;
                    assign w_id          = w_calc;
                    assign w_s0_dn_ready = w_r[0];
                end else begin : g_mid
                    assign w_iv = w_v[j-1];
                    assign w_id = w_d[j-1];
                end
                if (j == NB - 1) begin : g_tail
                    assign w_dr = w_adv;
                end else begin : g_next
                    assign w_dr = w_r[j+1];
                end
                agu_stage #(.W(ADR_W)) u_stage (
                    .clk     (clk),
                    .rst     (rst),
                    .i_flush (flush),
                    .i_valid (w_iv),
                    .i_data  (w_id),
                    .o_ready (w_r[j]),
                    .o_valid (w_v[j]),
                    .o_data  (w_d[j]),
                    .i_ready (w_dr)
                );
            end
            assign w_head       = w_d[NB-1];
            assign w_last_valid = w_v[NB-1];
        end
    endgenerate

    // Head pops on a plain beat, or on the second beat of a split.
    assign w_adv = result_ready && !flush &&
                   ((r_state == AGU_IDLE && !w_head.split) ||
                    (r_state == AGU_SPLIT1));

    assign w_base = {w_head.addr[XLEN-1:2], 2'b00};

    // Split FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= AGU_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Split FSM next state: beat 1 taken moves to SPLIT1.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = AGU_IDLE;
        end else begin
            unique case (r_state)
                AGU_IDLE: begin
                    if (w_last_valid && w_head.split && result_ready) begin
                        w_state_nxt = AGU_SPLIT1;
                    end
                end
                AGU_SPLIT1: begin
                    if (result_ready) begin
                        w_state_nxt = AGU_IDLE;
                    end
                end
                default: w_state_nxt = AGU_IDLE;
            endcase
        end
    end

    // Output beat: zero when idle or flushing.
    always_comb begin
        agu_result   = '0;
        result_mask  = 4'b0000;
        result_split = SPLIT_NONE;
        if (w_last_valid && !flush) begin
            agu_result.is_valid  = 1'b1;
            agu_result.dest_tag  = w_head.tag;
            agu_result.exception = w_head.exc;
            if (!w_head.split) begin
                agu_result.result = w_head.addr;
                result_mask       = w_head.m8[3:0];
            end else if (r_state == AGU_IDLE) begin
                agu_result.result = w_base;
                result_mask       = w_head.m8[3:0];
                result_split      = SPLIT_BEAT1;
            end else begin
                agu_result.result = w_base + {{(XLEN-3){1'b0}}, 3'b100};
                result_mask       = w_head.m8[7:4];
                result_split      = SPLIT_BEAT2;
            end
        end
    end

endmodule

// File: tb/tb_agu_pipe.sv
// Bench for agu_pipe: directed cases plus random traffic
// against a queue-based model, one unsplit and one split DUT.
module tb_agu_pipe;

    import uarch_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    instruction_t      pkt [2];
    logic [1:0]        sz  [2];
    logic              rdy [2];
    writeback_packet_t res [2];
    logic [3:0]        msk [2];
    logic [1:0]        spl [2];
    logic              rr  [2];

    agu_pipe #(.STAGES(2), .SPLIT_MISALIGNED(1'b0), .XLEN(32)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .agu_packet(pkt[0]), .agu_size(sz[0]), .agu_ready(rdy[0]),
        .agu_result(res[0]), .result_ready(rr[0]),
        .result_mask(msk[0]), .result_split(spl[0])
    );

    agu_pipe #(.STAGES(2), .SPLIT_MISALIGNED(1'b1), .XLEN(32)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .agu_packet(pkt[1]), .agu_size(sz[1]), .agu_ready(rdy[1]),
        .agu_result(res[1]), .result_ready(rr[1]),
        .result_mask(msk[1]), .result_split(spl[1])
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [63:0] mq [2][256];
    int hd [2];
    int tl [2];
    bit acc [2];
    int n_out [2];
    bit saw_stall;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] beat(input logic [5:0] t,
        input logic [31:0] ad, input logic e, input logic [3:0] m,
        input logic [1:0] s);
        return {19'd0, t, ad, e, m, s};
    endfunction

    task automatic push(input int d, input logic [63:0] b);
        mq[d][tl[d] % 256] = b;
        tl[d]++;
    endtask

    // Expected beats of one accepted uop, from plain arithmetic.
    task automatic model(input int d, input instruction_t p,
                         input logic [1:0] s);
        logic [31:0] ad;
        logic [31:0] base;
        int nb;
        int mi;
        logic [7:0] m;
        bit mis;
        ad = p.src_0_a.data + p.src_0_b.data;
        nb = (s == 0) ? 1 : (s == 1) ? 2 : 4;
        mi = ((1 << nb) - 1) << (ad % 4);
        m = mi[7:0];
        mis = (s == 3) || (s == 1 && ad % 2 != 0) ||
              (s == 2 && ad % 4 != 0);
        if (!mis) begin
            push(d, beat(p.dest_tag, ad, 1'b0, m[3:0], 2'd0));
        end else if (d == 0 || s == 3) begin
            push(d, beat(p.dest_tag, ad, 1'b1, m[3:0], 2'd0));
        end else begin
            base = ad & ~32'd3;
            push(d, beat(p.dest_tag, base, 1'b0, m[3:0], 2'd1));
            push(d, beat(p.dest_tag, base + 32'd4, 1'b0, m[7:4], 2'd2));
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            acc[d] = 1'b0;
            if (rst) begin
                hd[d] = 0;
                tl[d] = 0;
            end else if (flush) begin
                chk("flush_valid", res[d].is_valid, 0);
                chk("flush_ready", rdy[d], 0);
                hd[d] = tl[d];
            end else begin
                if (res[d].is_valid) begin
                    if (hd[d] == tl[d]) begin
                        chk("spurious_out", res[d].is_valid, 0);
                    end else begin
                        chk($sformatf("out%0d", d),
                            beat(res[d].dest_tag, res[d].result,
                                 res[d].exception, msk[d], spl[d]),
                            mq[d][hd[d] % 256]);
                        if (rr[d]) begin
                            hd[d]++;
                            n_out[d]++;
                        end
                    end
                end
                if (d == 0 && !rdy[0]) saw_stall = 1'b1;
                if (pkt[d].is_valid && rdy[d]) begin
                    model(d, pkt[d], sz[d]);
                    acc[d] = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input int d, input logic [5:0] t,
        input logic [31:0] a, input logic [31:0] b, input logic [1:0] s);
        pkt[d].is_valid     = 1'b1;
        pkt[d].dest_tag     = t;
        pkt[d].src_0_a.data = a;
        pkt[d].src_0_b.data = b;
        sz[d]               = s;
    endtask

    task automatic idle(input int d);
        pkt[d].is_valid = 1'b0;
    endtask

    task automatic wait_valid(input int d);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res[d].is_valid) return;
        end
        chk("timeout_valid", res[d].is_valid, 1);
    endtask

    task automatic rand_phase(input int d, input int ncyc,
                              input bit use_flush);
        logic [5:0] t;
        logic [1:0] s;
        t = 6'd32;
        for (int c = 0; c < ncyc; c++) begin
            step();
            rr[d] = ($urandom % 4) != 0;
            flush = use_flush && (($urandom % 40) == 0);
            if (acc[d] || !pkt[d].is_valid) begin
                if (($urandom % 4) != 0) begin
                    s = (($urandom % 8) == 0) ? 2'd3 : 2'($urandom % 3);
                    present(d, t, $urandom,
                            (($urandom % 2) != 0) ? $urandom
                                                  : $urandom_range(0, 15),
                            s);
                    t = t + 6'd1;
                end else begin
                    idle(d);
                end
            end
        end
        step();
        flush = 1'b0;
        idle(d);
        rr[d] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (hd[d] == tl[d]) break;
        end
        chk("drain_empty", tl[d] - hd[d], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] pat;
        int lat;
        int k;
        int start;
        pat = 4'b1001;
        for (int d = 0; d < 2; d++) begin
            pkt[d] = '0;
            sz[d] = 2'd0;
            rr[d] = 1'b1;
            hd[d] = 0;
            tl[d] = 0;
            n_out[d] = 0;
            acc[d] = 1'b0;
        end
        saw_stall = 1'b0;
        flush = 1'b0;
        rst = 1'b1;
        #12;
        for (int d = 0; d < 2; d++) begin
            chk("rst_result", res[d], 0);
            chk("rst_mask", msk[d], 0);
            chk("rst_split", spl[d], 0);
            chk("rst_ready", rdy[d], 1);
        end
        step();
        rst = 1'b0;

        // word 0x1000 + 0x24, two-cycle latency
        step();
        present(0, 6'd1, 32'h1000, 32'h24, 2'd2);
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 0) idle(0);
            @(negedge clk);
            if (res[0].is_valid) begin
                lat = i + 1;
                break;
            end
        end
        chk("latency", lat, 2);
        chk("w_result", res[0].result, 32'h1024);
        chk("w_mask", msk[0], 4'b1111);
        chk("w_exc", res[0].exception, 0);
        chk("w_split", spl[0], 0);
        chk("w_tag", res[0].dest_tag, 1);

        // misaligned word raises exception when not splitting
        step();
        present(0, 6'd2, 32'h1000, 32'h2, 2'd2);
        step();
        idle(0);
        wait_valid(0);
        chk("mis_exc", res[0].exception, 1);
        chk("mis_result", res[0].result, 32'h1002);
        chk("mis_mask", msk[0], 4'b1100);

        // byte address wraps past 2^32
        step();
        present(0, 6'd3, 32'hFFFF_FFFE, 32'h3, 2'd0);
        step();
        idle(0);
        wait_valid(0);
        chk("wrap_result", res[0].result, 32'h1);
        chk("wrap_mask", msk[0], 4'b0010);
        chk("wrap_exc", res[0].exception, 0);

        // split of word at 0x1003, next uop only after beat 2
        step();
        present(1, 6'd4, 32'h1000, 32'h3, 2'd2);
        step();
        present(1, 6'd5, 32'h2000, 32'h0, 2'd2);
        step();
        idle(1);
        wait_valid(1);
        chk("b1_result", res[1].result, 32'h1000);
        chk("b1_mask", msk[1], 4'b1000);
        chk("b1_split", spl[1], 2'b01);
        chk("b1_tag", res[1].dest_tag, 4);
        @(negedge clk);
        chk("b2_result", res[1].result, 32'h1004);
        chk("b2_mask", msk[1], 4'b0111);
        chk("b2_split", spl[1], 2'b10);
        chk("b2_tag", res[1].dest_tag, 4);
        @(negedge clk);
        chk("after_tag", res[1].dest_tag, 5);
        chk("after_split", spl[1], 0);
        chk("after_result", res[1].result, 32'h2000);

        // eight back-to-back words with 1,0,0,1 consumption
        step();
        start = n_out[0];
        saw_stall = 1'b0;
        k = 0;
        present(0, 6'd16, 32'h4000, 32'h40, 2'd2);
        for (int c = 0; c < 200; c++) begin
            rr[0] = pat[c % 4];
            step();
            if (acc[0]) begin
                k++;
                if (k < 8) begin
                    present(0, 6'(16 + k), 32'h4000 + 32'(k * 16),
                            32'h40, 2'd2);
                end else begin
                    idle(0);
                end
            end
            if (n_out[0] - start >= 8) break;
        end
        rr[0] = 1'b1;
        chk("b2b_count", n_out[0] - start, 8);
        chk("b2b_stall", saw_stall, 1);

        // flush in SPLIT1 with two more uops behind
        repeat (3) step();
        present(1, 6'd8, 32'h3000, 32'h3, 2'd2);
        step();
        present(1, 6'd9, 32'h4000, 32'h0, 2'd2);
        step();
        present(1, 6'd10, 32'h5000, 32'h0, 2'd2);
        @(negedge clk);
        chk("fl_beat1", spl[1], 2'b01);
        step();
        flush = 1'b1;
        rr[1] = 1'b0;
        @(negedge clk);
        chk("fl_cyc_valid", res[1].is_valid, 0);
        chk("fl_cyc_ready", rdy[1], 0);
        step();
        flush = 1'b0;
        idle(1);
        rr[1] = 1'b1;
        @(negedge clk);
        chk("post_fl_valid", res[1].is_valid, 0);
        chk("post_fl_split", spl[1], 0);
        chk("post_fl_ready", rdy[1], 1);
        step();
        present(1, 6'd11, 32'h6000, 32'h1, 2'd0);
        step();
        idle(1);
        wait_valid(1);
        chk("post_fl_tag", res[1].dest_tag, 11);
        chk("post_fl_nosplit", spl[1], 0);

        // async reset while an output is held
        step();
        rr[0] = 1'b0;
        present(0, 6'd12, 32'h100, 32'h20, 2'd2);
        step();
        idle(0);
        wait_valid(0);
        chk("pre_rst_valid", res[0].is_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_result", res[0], 0);
        chk("arst_mask", msk[0], 0);
        chk("arst_split", spl[0], 0);
        chk("arst_ready", rdy[0], 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rr[0] = 1'b1;

        // random traffic, unsplit then split with flushes
        rand_phase(0, 400, 1'b0);
        rand_phase(1, 400, 1'b1);
        rand_phase(0, 200, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
